// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file arbiter.
package regfile_pkg;

    // Controller mode: clearing the file, or serving requesters.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Number of requesters sharing the register file.
    localparam int NUM_REQ = 2;

endpackage

// File: rtl/regfile_arbiter_rr.sv
// Two-way round-robin grant logic with its own fairness pointer.
module rr_arbiter
    import regfile_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic [NUM_REQ-1:0] i_valid,
    output logic [NUM_REQ-1:0] o_grant
);

    // Requester that wins when both are valid.
    logic r_ptr;

    // Grant is purely combinational from the valids and the pointer.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
        o_grant = '0;
        if (i_enable) begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
                default: o_grant = '0;
            endcase
        end
    end

    // After any grant, priority passes to the requester that did not win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (|o_grant) begin
            // NOTE: sequential state is updated with <= so every flop samples pre-edge values regardless of statement order.
            r_ptr <= o_grant[0];
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto an external register file and clears
// the file on reset or on request.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       reqValid,
    input  logic [NUM_REQ-1:0]       reqWrite,
    input  logic [NUM_REQ*DEPTH-1:0] reqAddr,
    input  logic [NUM_REQ*WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]       reqReady,
    output logic [NUM_REQ-1:0]       rspValid,
    output logic [WIDTH-1:0]         rspData,
    input  logic                     initStart,
    output logic                     busy,
    output logic                     rfWriteEnable,
    output logic [DEPTH-1:0]         rfWriteAddr,
    output logic [WIDTH-1:0]         rfWriteData,
    output logic [DEPTH-1:0]         rfReadAddr,
    input  logic [WIDTH-1:0]         rfReadData
);

    state_e               r_state;
    state_e               w_next_state;
    logic [DEPTH-1:0]     r_sweep_cnt;
    logic                 w_sweep_last;

    logic                 w_arb_enable;
    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_any_grant;
    logic                 w_sel;
    logic                 w_sel_write;
    logic [DEPTH-1:0]     w_sel_addr;
    logic [WIDTH-1:0]     w_sel_data;

    logic                 r_wr_en;
    logic [DEPTH-1:0]     r_wr_addr;
    logic [WIDTH-1:0]     r_wr_data;
    logic [DEPTH-1:0]     r_rd_addr;
    logic [NUM_REQ-1:0]   r_rd_pend;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [WIDTH-1:0]     r_rsp_data;

    assign w_sweep_last = (r_sweep_cnt == {DEPTH{1'b1}});

    // A clear request takes the cycle away from the requesters.
    assign w_arb_enable = (r_state == ST_RUN) && !initStart;

    rr_arbiter u_rr_arbiter (
        .clk      (clk),
        .rst_n    (reset),
        .i_enable (w_arb_enable),
        .i_valid  (reqValid),
        .o_grant  (w_grant)
    );

    // Steer the granted requester's command onto one internal bus.
    assign w_any_grant = |w_grant;
    assign w_sel       = w_grant[1];
    assign w_sel_write = reqWrite[w_sel];
    assign w_sel_addr  = w_sel ? reqAddr[2*DEPTH-1:DEPTH] : reqAddr[DEPTH-1:0];
    assign w_sel_data  = w_sel ? reqData[2*WIDTH-1:WIDTH] : reqData[WIDTH-1:0];

    assign reqReady      = w_grant;
    assign busy          = (r_state == ST_INIT);
    assign rfWriteEnable = r_wr_en;
    assign rfWriteAddr   = r_wr_addr;
    assign rfWriteData   = r_wr_data;
    assign rfReadAddr    = r_rd_addr;
    assign rspValid      = r_rsp_valid;
    assign rspData       = r_rsp_data;

    // Mode register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Leave the sweep after the last address; a clear request restarts it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT: if (w_sweep_last) w_next_state = ST_RUN;
            ST_RUN:  if (initStart)    w_next_state = ST_INIT;
            default: w_next_state = ST_INIT;
        endcase
    end

    // Sweep address walks up during the clear and parks at zero otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sweep_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_sweep_cnt <= r_sweep_cnt + 1'b1;
        end else begin
            r_sweep_cnt <= '0;
        end
    end

    // Single write stage shared by the clear sweep and requester writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (r_state == ST_INIT) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_sweep_cnt;
            r_wr_data <= '0;
        end else if (w_any_grant && w_sel_write) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    // Read stage: register the address and remember who asked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_addr <= '0;
            r_rd_pend <= '0;
        end else begin
            r_rd_pend <= (w_any_grant && !w_sel_write) ? w_grant : '0;
            if (w_any_grant && !w_sel_write) begin
                r_rd_addr <= w_sel_addr;
            end
        end
    end

    // Response stage: capture file data and pulse the asker's valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= r_rd_pend;
            if (|r_rd_pend) begin
                r_rsp_data <= rfReadData;
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed scenarios plus random
// traffic, compared against a transaction-level model of the file.
module tb_regfile_arbiter;
    localparam int WIDTH = 32;
    localparam int DEPTH = 5;
    localparam int N     = 1 << DEPTH;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         reqValid;
    logic [1:0]         reqWrite;
    logic [2*DEPTH-1:0] reqAddr;
    logic [2*WIDTH-1:0] reqData;
    logic [1:0]         reqReady;
    logic [1:0]         rspValid;
    logic [WIDTH-1:0]   rspData;
    logic               initStart;
    logic               busy;
    logic               rfWriteEnable;
    logic [DEPTH-1:0]   rfWriteAddr;
    logic [WIDTH-1:0]   rfWriteData;
    logic [DEPTH-1:0]   rfReadAddr;
    logic [WIDTH-1:0]   rfReadData;

    regfile_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .reqValid      (reqValid),
        .reqWrite      (reqWrite),
        .reqAddr       (reqAddr),
        .reqData       (reqData),
        .reqReady      (reqReady),
        .rspValid      (rspValid),
        .rspData       (rspData),
        .initStart     (initStart),
        .busy          (busy),
        .rfWriteEnable (rfWriteEnable),
        .rfWriteAddr   (rfWriteAddr),
        .rfWriteData   (rfWriteData),
        .rfReadAddr    (rfReadAddr),
        .rfReadData    (rfReadData)
    );

    always #5 clk = ~clk;

    // External register file: async read, write at the rising edge.
    logic [WIDTH-1:0] rf_mem [N];
    initial begin
        for (int i = 0; i < N; i++) rf_mem[i] = 32'hA5A5_0000 | WIDTH'(i);
        forever begin
            @(posedge clk);
            if (rfWriteEnable) rf_mem[rfWriteAddr] <= rfWriteData;
        end
    end
    assign rfReadData = rf_mem[rfReadAddr];

    // Reference model state.
    logic [WIDTH-1:0] exp_mem [N];
    bit               m_sweep;
    int               m_idx;
    bit               m_ptr;
    bit               m_we;
    logic [DEPTH-1:0] m_wa;
    logic [WIDTH-1:0] m_wd;
    logic [1:0]       m_rv1, m_rv;
    logic [WIDTH-1:0] m_rd1, m_rdata;
    logic [DEPTH-1:0] m_rda;
    bit               m_rda_chk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sweep = 1'b1; m_idx = 0; m_ptr = 1'b0;
        m_we = 1'b0; m_wa = '0; m_wd = '0;
        m_rv1 = '0; m_rv = '0; m_rd1 = '0; m_rdata = '0;
        m_rda = '0; m_rda_chk = 1'b0;
    endtask

    // Who should be granted, from the round-robin rules.
    function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic start);
        if (m_sweep || start || v == 2'b00) return 2'b00;
        if (v == 2'b11) return m_ptr ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic set_req(input int i, input bit v, input bit w,
                           input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
        reqValid[i] = v;
        reqWrite[i] = w;
        reqAddr[i*DEPTH +: DEPTH] = a;
        reqData[i*WIDTH +: WIDTH] = d;
    endtask

    // One clock: check outputs mid-cycle, then advance the model.
    task automatic cycle();
        logic [1:0]       g;
        int               who;
        logic [DEPTH-1:0] a;
        @(negedge clk);
        g = exp_grant(reqValid, initStart);
        check("busy", busy, m_sweep);
        check("reqReady", reqReady, g);
        check("rfWriteEnable", rfWriteEnable, m_we);
        if (m_we) begin
            check("rfWriteAddr", rfWriteAddr, m_wa);
            check("rfWriteData", rfWriteData, m_wd);
        end
        check("rspValid", rspValid, m_rv);
        if (m_rv != 2'b00) check("rspData", rspData, m_rdata);
        if (m_rda_chk) check("rfReadAddr", rfReadAddr, m_rda);
        m_rv = m_rv1; m_rdata = m_rd1; m_rv1 = '0;
        m_we = 1'b0; m_rda_chk = 1'b0;
        if (m_sweep) begin
            m_we = 1'b1; m_wa = DEPTH'(m_idx); m_wd = '0;
            exp_mem[m_idx] = '0;
            m_idx++;
            if (m_idx == N) m_sweep = 1'b0;
        end else if (initStart) begin
            m_sweep = 1'b1; m_idx = 0;
        end else if (g != 2'b00) begin
            who   = g[1] ? 1 : 0;
            m_ptr = (who == 0);
            a     = reqAddr[who*DEPTH +: DEPTH];
            if (reqWrite[who]) begin
                m_we = 1'b1; m_wa = a; m_wd = reqData[who*WIDTH +: WIDTH];
                exp_mem[a] = m_wd;
            end else begin
                m_rv1 = g; m_rd1 = exp_mem[a];
                m_rda = a; m_rda_chk = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".busy"}, busy, 1'b1);
        check({tag, ".reqReady"}, reqReady, 2'b00);
        check({tag, ".rfWriteEnable"}, rfWriteEnable, 1'b0);
        check({tag, ".rfWriteAddr"}, rfWriteAddr, '0);
        check({tag, ".rfWriteData"}, rfWriteData, '0);
        check({tag, ".rfReadAddr"}, rfReadAddr, '0);
        check({tag, ".rspValid"}, rspValid, 2'b00);
        check({tag, ".rspData"}, rspData, '0);
    endtask

    // Hard time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit reached");
    end

    initial begin
        for (int i = 0; i < N; i++) exp_mem[i] = 32'hA5A5_0000 | WIDTH'(i);
        reset = 1'b0; initStart = 1'b0;
        reqValid = '0; reqWrite = '0; reqAddr = '0; reqData = '0;
        model_reset();

        // Reset state, with both requesters already asking.
        set_req(0, 1, 0, 5'd3, '0);
        set_req(1, 1, 0, 5'd4, '0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");

        // Release: 32-cycle clear sweep, then ready in the next cycle.
        reset = 1'b1;
        repeat (N) cycle();
        reqValid = 2'b00;
        cycle();

        // Write 5 <- DEADBEEF by requester 0, read 5 by requester 1 next cycle.
        set_req(0, 1, 1, 5'd5, 32'hDEAD_BEEF);
        set_req(1, 0, 0, 5'd0, '0);
        cycle();
        set_req(0, 0, 0, 5'd0, '0);
        set_req(1, 1, 0, 5'd5, '0);
        cycle();
        reqValid = 2'b00;
        cycle();
        check("raw.rspValid", rspValid, 2'b10);
        check("raw.rspData", rspData, 32'hDEAD_BEEF);
        cycle();

        // Continuous reads from both: grants alternate starting at requester 0.
        set_req(0, 1, 0, 5'd5, '0);
        set_req(1, 1, 0, 5'd7, '0);
        for (int k = 0; k < 6; k++) begin
            #1;
            check("alt.reqReady", reqReady, (k % 2 == 0) ? 2'b01 : 2'b10);
            cycle();
        end
        reqValid = 2'b00;
        repeat (2) cycle();

        // Read accepted just before a clear request keeps its old data.
        set_req(0, 1, 1, 5'd9, 32'h1234_5678);
        cycle();
        set_req(0, 0, 0, 5'd0, '0);
        set_req(1, 1, 0, 5'd9, '0);
        cycle();
        set_req(0, 1, 0, 5'd5, '0);
        set_req(1, 1, 0, 5'd9, '0);
        initStart = 1'b1;
        cycle();
        initStart = 1'b0;
        check("presweep.rspValid", rspValid, 2'b10);
        check("presweep.rspData", rspData, 32'h1234_5678);
        for (int k = 0; k < N; k++) begin
            check("sweep.reqReady", reqReady, 2'b00);
            cycle();
        end

        // After the clear, address 5 reads back as zero.
        set_req(0, 1, 0, 5'd5, '0);
        set_req(1, 0, 0, 5'd0, '0);
        cycle();
        reqValid = 2'b00;
        cycle();
        check("cleared.rspValid", rspValid, 2'b01);
        check("cleared.rspData", rspData, '0);
        cycle();

        // Reset in the middle of a sweep, at address 10.
        initStart = 1'b1;
        cycle();
        initStart = 1'b0;
        repeat (11) cycle();
        check("midsweep.rfWriteAddr", rfWriteAddr, 5'd10);
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        repeat (N + 1) cycle();

        // Random traffic with occasional clear requests.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++)
                set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        DEPTH'($urandom_range(0, N - 1)), $urandom);
            initStart = ($urandom_range(0, 59) == 0);
            cycle();
        end
        reqValid = 2'b00; initStart = 1'b0;
        repeat (N + 4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
